// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode handshake, and execute control.
// The master side belongs to fetch_unit; the slave side is the surrounding core.
interface fetch_unit_if;
    logic [15:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        resume;
    logic        halted;

    modport master (
        output imem_pc,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect,
        input  redirect_pc,
        input  resume,
        output halted
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect,
        output redirect_pc,
        output resume,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: owns the PC, queues {pc, instr} pairs for decode,
// flushes on redirect from execute and stops fetching after an EBREAK.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] EBREAK_WORD = 32'h00100073
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q;
    logic [31:0]   buf_instr [DEPTH];
    logic [15:0]   buf_pc    [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          valid, pop, push, full_after_pop;

    // Only word-aligned targets are meaningful; the low bits are dropped.
    wire unused_rpc_lsbs = &{1'b0, fif.redirect_pc[1:0]};

    assign valid          = (count_q != '0);
    assign pop            = valid && fif.out_ready;
    assign full_after_pop = (count_q == DEPTH_C) && !pop;

    assign fif.imem_pc   = pc_q;
    assign fif.out_valid = valid;
    assign fif.out_instr = buf_instr[head_q];
    assign fif.out_pc    = buf_pc[head_q];
    assign fif.halted    = (state_q == HALTED);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (fif.redirect) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!full_after_pop) begin
                        push = 1'b1;
                        if (fif.imem_instr == EBREAK_WORD) state_d = HALTED;
                    end
                end
                HALTED: begin
                    if (fif.resume) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // Head outputs must read zero straight after reset, so storage is cleared too.
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (fif.redirect) begin
                pc_q    <= {fif.redirect_pc[15:2], 2'b00};
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    buf_instr[tail_q] <= fif.imem_instr;
                    buf_pc[tail_q]    <= pc_q;
                    tail_q            <= tail_q + PW'(1);
                    pc_q              <= pc_q + 16'd4;
                end
                if (pop) head_q <= head_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic clk = 1'b0;
    logic rst, rst1;
    always #5 clk = ~clk;

    logic [31:0] mem [16384];

    fetch_unit_if fif0 ();
    fetch_unit_if fif1 ();

    assign fif0.imem_instr = mem[fif0.imem_pc[15:2]];
    assign fif1.imem_instr = mem[fif1.imem_pc[15:2]];

    fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2), .EBREAK_WORD(EBREAK)) dut (
        .clk(clk), .rst(rst), .fif(fif0));

    fetch_unit #(.RESET_PC(16'hFFF8), .DEPTH(2), .EBREAK_WORD(EBREAK)) dut_wrap (
        .clk(clk), .rst(rst1), .fif(fif1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rd,
                         input logic [15:0] rpc, input logic res);
        rst                  = r;
        fif0.out_ready       = rdy;
        fif0.redirect        = rd;
        fif0.redirect_pc     = rpc;
        fif0.resume          = res;
    endtask

    task automatic load_base();
        for (int i = 0; i < 16384; i++) mem[i] = 32'h00000013;
        mem[0]  = 32'h00300413;
        mem[1]  = 32'h00100493;
        mem[2]  = 32'h01000913;
        mem[3]  = 32'h00c00613;
        mem[4]  = 32'h00d00693;
        mem[5]  = 32'h01228863;
        mem[6]  = 32'h00e00713;
        mem[7]  = 32'h00f00793;
        mem[8]  = 32'hff5ff06f;
        mem[16] = 32'h00000513;
    endtask

    typedef struct packed {
        logic        rst;
        logic        ready;
        logic        redirect;
        logic [15:0] rpc;
        logic        resume;
        logic        valid;
        logic [15:0] opc;
        logic [31:0] oinstr;
        logic [15:0] ipc;
        logic        halted;
        logic        chkdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq [$];
    logic [15:0] mpc;
    bit          mhalt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found, saw24;
        logic [15:0] heads [$];
        logic [15:0] exp_wrap [4];

        rst1 = 1'b1;
        fif1.out_ready = 1'b1; fif1.redirect = 1'b0; fif1.redirect_pc = '0; fif1.resume = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        load_base();

        //            rst  rdy  rd   rpc      res  vld  opc      oinstr        ipc      hlt  chk
        vecs[0]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,32'h00000000,16'h0000,1'b0,1'b1};
        vecs[1]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0000,32'h00300413,16'h0004,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0004,32'h00100493,16'h0008,1'b0,1'b1};
        vecs[3]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0008,32'h01000913,16'h000C,1'b0,1'b1};
        vecs[4]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0008,32'h01000913,16'h0010,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0008,32'h01000913,16'h0010,1'b0,1'b1};
        vecs[6]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0008,32'h01000913,16'h0010,1'b0,1'b1};
        vecs[7]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h000C,32'h00c00613,16'h0014,1'b0,1'b1};
        vecs[8]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0010,32'h00d00693,16'h0018,1'b0,1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0014,32'h01228863,16'h001C,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0014,32'h01228863,16'h001C,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b1,16'h0042,1'b0,1'b0,16'h0000,32'h00000000,16'h0040,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0040,32'h00000513,16'h0044,1'b0,1'b1};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].ready, vecs[i].redirect, vecs[i].rpc, vecs[i].resume);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(fif0.out_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_imem_pc", i), 32'(fif0.imem_pc), 32'(vecs[i].ipc));
            chk($sformatf("vec%0d_halted", i), 32'(fif0.halted), 32'(vecs[i].halted));
            if (vecs[i].chkdata) begin
                chk($sformatf("vec%0d_out_pc", i), 32'(fif0.out_pc), 32'(vecs[i].opc));
                chk($sformatf("vec%0d_out_instr", i), fif0.out_instr, vecs[i].oinstr);
            end
        end

        // Backward jump: redirect while the jump itself is accepted at the head
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (fif0.out_valid && fif0.out_pc == 16'd32) found = 1'b1;
        end
        chk("jmp_reach_pc32", 32'(found), 32'd1);
        chk("jmp_head_instr", fif0.out_instr, 32'hff5ff06f);
        drive(1'b0, 1'b1, 1'b1, 16'd20, 1'b0); step();
        chk("jmp_flush_valid", 32'(fif0.out_valid), 32'd0);
        chk("jmp_imem_pc", 32'(fif0.imem_pc), 32'd20);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0); step();
        chk("jmp_target_valid", 32'(fif0.out_valid), 32'd1);
        chk("jmp_target_pc", 32'(fif0.out_pc), 32'd20);
        chk("jmp_target_instr", fif0.out_instr, 32'h01228863);

        // EBREAK halt and resume
        mem[6] = EBREAK;
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        found = 1'b0; saw24 = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (fif0.out_valid && fif0.out_pc == 16'd24 && fif0.out_instr == EBREAK) saw24 = 1'b1;
            if (fif0.halted) found = 1'b1;
        end
        chk("ebrk_halted", 32'(found), 32'd1);
        chk("ebrk_entry24", 32'(saw24), 32'd1);
        chk("ebrk_imem_pc", 32'(fif0.imem_pc), 32'd28);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("ebrk_hold%0d_pc", c), 32'(fif0.imem_pc), 32'd28);
            chk($sformatf("ebrk_hold%0d_halted", c), 32'(fif0.halted), 32'd1);
            chk($sformatf("ebrk_hold%0d_valid", c), 32'(fif0.out_valid), 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1); step();
        chk("resume_halted", 32'(fif0.halted), 32'd0);
        chk("resume_valid", 32'(fif0.out_valid), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0); step();
        chk("resume_head_valid", 32'(fif0.out_valid), 32'd1);
        chk("resume_head_pc", 32'(fif0.out_pc), 32'd28);
        mem[6] = 32'h00e00713;

        // Reset with buffer full, halted, and redirect/resume all asserted
        mem[1] = EBREAK;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0); step(); step();
        chk("rstmid_pre_halted", 32'(fif0.halted), 32'd1);
        chk("rstmid_pre_count", 32'(dut.count_q), 32'd2);
        drive(1'b1, 1'b0, 1'b1, 16'h0080, 1'b1); step();
        chk("rstmid_valid", 32'(fif0.out_valid), 32'd0);
        chk("rstmid_halted", 32'(fif0.halted), 32'd0);
        chk("rstmid_imem_pc", 32'(fif0.imem_pc), 32'd0);
        chk("rstmid_out_pc", 32'(fif0.out_pc), 32'd0);
        chk("rstmid_out_instr", fif0.out_instr, 32'd0);
        mem[1] = 32'h00100493;

        // PC wrap on the second instance
        exp_wrap[0] = 16'hFFF8; exp_wrap[1] = 16'hFFFC; exp_wrap[2] = 16'h0000; exp_wrap[3] = 16'h0004;
        rst1 = 1'b1; step();
        rst1 = 1'b0;
        for (int c = 0; c < 12 && heads.size() < 4; c++) begin
            step();
            if (fif1.out_valid) heads.push_back(fif1.out_pc);
        end
        chk("wrap_head_count", 32'(heads.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrap_head%0d", k), (k < heads.size()) ? 32'(heads[k]) : 32'hDEAD, 32'(exp_wrap[k]));

        // Randomized run against the queue model
        for (int i = 0; i < 16384; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? EBREAK : $urandom;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0); step();
        mq.delete(); mpc = 16'h0000; mhalt = 0;
        for (int c = 0; c < 1500; c++) begin
            logic        r_rst, r_rdy, r_rd, r_res, m_pop;
            logic [15:0] r_rpc;
            logic [31:0] w;
            r_rst = ($urandom_range(0, 99) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_rd  = ($urandom_range(0, 99) < 6);
            r_res = ($urandom_range(0, 3) == 0);
            r_rpc = 16'($urandom);
            drive(r_rst, r_rdy, r_rd, r_rpc, r_res);
            m_pop = (mq.size() > 0) && r_rdy;
            if (r_rst) begin
                mq.delete(); mpc = 16'h0000; mhalt = 0;
            end else if (r_rd) begin
                mq.delete(); mpc = r_rpc & 16'hFFFC; mhalt = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (!mhalt) begin
                    if (mq.size() < 2) begin
                        w = mem[mpc[15:2]];
                        mq.push_back('{pc: mpc, instr: w});
                        mpc = mpc + 16'd4;
                        if (w == EBREAK) mhalt = 1;
                    end
                end else if (r_res) begin
                    mhalt = 0;
                end
            end
            step();
            chk("rnd_valid", 32'(fif0.out_valid), 32'(mq.size() > 0));
            chk("rnd_imem_pc", 32'(fif0.imem_pc), 32'(mpc));
            chk("rnd_halted", 32'(fif0.halted), 32'(mhalt));
            chk("rnd_count", 32'(dut.count_q), 32'(mq.size()));
            chk("rnd_count_le_depth", 32'(dut.count_q <= 2'd2), 32'd1);
            if (mq.size() > 0) begin
                chk("rnd_out_pc", 32'(fif0.out_pc), 32'(mq[0].pc));
                chk("rnd_out_instr", fif0.out_instr, mq[0].instr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
